uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that drains the byte FIFO sitting directly upstream of it. It pops one byte whenever the FIFO is non-empty, the frame engine is idle and the remote end permits sending (CTS). It then shifts the byte out LSB-first on `tx_o` as a start/data/parity/stop frame, with a run-time programmable bit period in clk6x cycles. It is the transmit back-end of NORA's host-visible UART; the CPU-side register block only ever writes into the FIFO.

## Interface
- `DIVBITS`, default 16: width of the bit-period divisor.
- `clk6x  in  1`: system clock, 48 MHz.
- `resetn  in  1`: synchronous reset, active-low. Sampled on `clk6x`.
- `fifo_data_i  in  8`: FIFO read-port data. Valid whenever `fifo_empty_i` = 0.
- `fifo_empty_i  in  1`: FIFO empty flag.
- `fifo_deq_o  out  1`: one-cycle dequeue strobe to the FIFO.
- `baud_div_i  in  DIVBITS`: bit period minus 1, in clk6x cycles. For example, 416 gives 417 cycles, about 115108 Bd.
- `parity_i  in  2`: parity mode. 00 = none, 01 = odd, 10 = even, 11 = treated as none.
- `two_stop_i  in  1`: 1 = two stop bits, 0 = one.
- `cts_n_i  in  1`: clear-to-send, active-low, asynchronous.
- `tx_o  out  1`: serial line. Idle/mark = 1.
- `busy_o  out  1`: 1 while a frame is in progress, from START through the last stop bit.
- `done_o  out  1`: one-cycle pulse on the last cycle of the final stop bit.

## Operation
- **CTS input:** `cts_n_i` passes through a 2-flop synchronizer; `cts_ok` = the synchronized value is 0. CTS is evaluated only in IDLE. Deassertion mid-frame never truncates the frame.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx_o` = 1.
  - If `!fifo_empty_i && cts_ok`:
    - latch `fifo_data_i` into the shift register;
    - latch `baud_div_i`, `parity_i` and `two_stop_i` into frame config;
    - pulse `fifo_deq_o` for exactly this cycle;
    - go to START.
- **START:** `tx_o` = 0 for one bit period, then go to DATA.
- **DATA:**
  - Eight bit periods, each driving `tx_o` = shift[0]; shift right at the end of each period.
  - A 3-bit counter counts the bits; after bit 7, go to PARITY if parity is enabled, else STOP.
- **PARITY:** one bit period.
  - Even mode: `tx_o` = XOR of the 8 data bits.
  - Odd mode: `tx_o` = the inverse of that XOR.
  - The XOR is computed at load time from the latched byte.
- **STOP:**
  - `tx_o` = 1 for 1 or 2 bit periods, per the latched `two_stop_i`.
  - On the final cycle, pulse `done_o` and go to IDLE.
- **Bit timer:**
  - Down-counter loaded with the latched divisor at each bit start; a bit ends when the counter is 0.
  - Bit length = divisor + 1 cycles; divisor 0 gives 1 cycle per bit, which is legal.
  - The counter is DIVBITS wide; no wrap occurs since it only counts down to 0.
- **Config latching:** changes to `baud_div_i`, `parity_i` or `two_stop_i` mid-frame have no effect until the next frame.
- **Registered outputs:** `tx_o` and `busy_o` are registered; no combinational path exists from any input to `tx_o`.

## Timing
- **Reset values:**
  - `tx_o` = 1, `fifo_deq_o` = 0, `busy_o` = 0, `done_o` = 0;
  - state = IDLE;
  - synchronizer flops = 1, i.e. not clear.
- **Reset mid-frame:** `tx_o` is 1 on the first reset cycle. The in-flight byte is lost and the FIFO is not touched.
- **Start latency:** with CTS already synchronized low, FIFO non-empty at cycle N gives:
  - `fifo_deq_o` = 1 at cycle N;
  - `tx_o` = 0 and `busy_o` = 1 from cycle N+1.
- **CTS latency:** a CTS falling edge takes 2–3 cycles to reach `cts_ok`.
- **Frame length:** (1 + 8 + P + S) × (div + 1) cycles, where P is 0/1 and S is 1/2.
- **Back-to-back frames:**
  - After `done_o` at cycle M, the state is IDLE at M+1.
  - Dequeue happens at M+1 and the start bit begins at M+2.
  - Inter-frame gap is therefore exactly 1 extra mark cycle.
- **Empty FIFO:** `fifo_deq_o` is never asserted while `fifo_empty_i` = 1, and never for two consecutive cycles.
- **Simultaneous FIFO enqueue:** FIFO goes non-empty in the same cycle as `done_o`. This is handled by the IDLE check at M+1; nothing special is needed.

## Structure
- **Shared package `uart_pkg`:**
  - parity mode constants `PAR_NONE`=2'b00, `PAR_ODD`=2'b01, `PAR_EVEN`=2'b10;
  - state encoding constants.
  - The package is shared with the future `uart_rx`.
- **Sub-module `uart_bit_timer`:**
  - loadable DIVBITS down-counter with `load`, `div` and `tick` (count = 0) ports;
  - reused by `uart_rx` with a half-bit preload.
- **CTS synchronizer:** inline, 2 flops.

## Test plan
- **Single byte, 8N1, divisor 4:** `baud_div`=4, `parity`=00, one stop bit, 0x55 written to the FIFO.
  - `fifo_deq_o` pulses once.
  - `tx_o` shows 0,1,0,1,0,1,0,1,0,1, each level held 5 cycles.
  - `done_o` fires at cycle 50 after the dequeue; the FIFO ends empty.
- **Parity modes:** byte 0x07, divisor 2, even parity, then odd parity.
  - Even: parity bit = 1. Odd: parity bit = 0.
  - Frame = 11 bits × 3 cycles; stop bit = 1.
- **Back-to-back, two stop bits:** bytes 0xA3 then 0xFF enqueued together, `two_stop_i`=1, divisor 0.
  - Frames of 11 cycles each, separated by exactly 1 mark cycle.
  - Two dequeue pulses, 12 cycles apart.
- **CTS gating:** `cts_n_i`=1 with a byte queued for 100 cycles, then 0.
  - No `fifo_deq_o` and `tx_o`=1 throughout the blocked period.
  - Dequeue within 3 cycles of the CTS fall.
  - Raising CTS mid-frame does not truncate the frame.
- **Reset mid-frame and config change:**
  - Assert `resetn`=0 during DATA bit 3: `tx_o`=1 next cycle and `busy_o`=0.
  - Separately, change `baud_div` 4→9 mid-frame: the current frame stays at 5 cycles/bit and the next frame uses 10.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : parity modes and frame-engine state encoding shared by the UART.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// uart_tx_if : byte-FIFO read port feeding the UART transmitter.
// Revision   : 1.0
// ============================================================================
interface uart_tx_if;

  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_deq;

  modport master (input fifo_data, input fifo_empty, output fifo_deq);
  modport slave  (output fifo_data, output fifo_empty, input fifo_deq);

endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// uart_bit_timer : loadable down-counter; tick_o while the count is zero.
// Revision       : 1.0
// ============================================================================
module uart_bit_timer #(
  parameter int DIVBITS = 16
) (
  input  logic               clk6x,
  input  logic               resetn,
  input  logic               load_i,
  input  logic [DIVBITS-1:0] div_i,
  output logic               tick_o
);

  logic [DIVBITS-1:0] cnt_q;
  logic [DIVBITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIVBITS'(1);
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : FIFO-draining UART transmitter, LSB first, optional parity and
//           one or two stop bits, run-time bit period in clk6x cycles.
// Revision: 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVBITS = 16
) (
  input  logic               clk6x,
  input  logic               resetn,
  uart_tx_if.master          fifo,
  input  logic [DIVBITS-1:0] baud_div_i,
  input  logic [1:0]         parity_i,
  input  logic               two_stop_i,
  input  logic               cts_n_i,
  output logic               tx_o,
  output logic               busy_o,
  output logic               done_o
);

  uart_state_e        state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic               stop2_q, stop2_d;
  logic [DIVBITS-1:0] div_q, div_d;
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
  logic               two_stop_q, two_stop_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               cts_s1_q, cts_s2_q;

  logic               cts_ok;
  logic               deq;
  logic               done;
  logic               tmr_load;
  logic [DIVBITS-1:0] tmr_div;
  logic               tick;

  uart_bit_timer #(.DIVBITS(DIVBITS)) u_timer (
    .clk6x  (clk6x),
    .resetn (resetn),
    .load_i (tmr_load),
    .div_i  (tmr_div),
    .tick_o (tick)
  );

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      cts_s1_q <= cts_n_i;
      cts_s2_q <= cts_s1_q;
    end
  end

  assign cts_ok = !cts_s2_q;

  // tx_d/busy_d describe the line level of the *next* cycle, keeping tx_o a pure flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    deq        = 1'b0;
    done       = 1'b0;
    tmr_load   = 1'b0;
    tmr_div    = div_q;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo.fifo_empty && cts_ok) begin
          shift_d    = fifo.fifo_data;
          div_d      = baud_div_i;
          par_en_d   = parity_enabled(parity_i);
          par_bit_d  = (^fifo.fifo_data) ^ (parity_i == PAR_ODD);
          two_stop_d = two_stop_i;
          stop2_d    = 1'b0;
          deq        = 1'b1;
          tmr_load   = 1'b1;
          tmr_div    = baud_div_i;
          state_d    = ST_START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          tmr_load = 1'b1;
          bitcnt_d = 3'd0;
          state_d  = ST_DATA;
          tx_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          tmr_load = 1'b1;
          shift_d  = {1'b0, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tmr_load = 1'b1;
          state_d  = ST_STOP;
          tx_d     = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (two_stop_q && !stop2_q) begin
            tmr_load = 1'b1;
            stop2_d  = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo.fifo_deq = deq & resetn;
  assign done_o        = done & resetn;
  assign tx_o          = tx_q;
  assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : directed frame-table bench for uart_tx.
// Revision   : 1.0
// ============================================================================
module tb_uart_tx;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        two;
    logic [11:0] frame;
    int          nbits;
    int          len;
  } vec_t;

  logic        clk6x;
  logic        resetn;
  logic [15:0] baud_div;
  logic [1:0]  parity;
  logic        two_stop;
  logic        cts_n;
  logic        tx;
  logic        busy;
  logic        done;

  uart_tx_if ifc ();

  uart_tx #(.DIVBITS(16)) dut (
    .clk6x      (clk6x),
    .resetn     (resetn),
    .fifo       (ifc),
    .baud_div_i (baud_div),
    .parity_i   (parity),
    .two_stop_i (two_stop),
    .cts_n_i    (cts_n),
    .tx_o       (tx),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk6x = 1'b0;
  always #5 clk6x = ~clk6x;

  logic [7:0] q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_no = 0;
  int   deq_empty_err = 0;
  int   deq_dbl_err = 0;
  logic last_deq = 1'b0;
  logic s_tx, s_busy, s_done, s_deq;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    ifc.fifo_empty = (q.size() == 0);
    ifc.fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
    #1;
  endtask

  // One clock: pop on an accepted dequeue, then sample outputs mid-cycle.
  task automatic cyc();
    logic d;
    d = ifc.fifo_deq;
    if (d === 1'b1 && q.size() == 0) deq_empty_err++;
    if (d === 1'b1 && last_deq === 1'b1) deq_dbl_err++;
    last_deq = d;
    @(posedge clk6x);
    #1;
    if (d === 1'b1 && q.size() > 0) void'(q.pop_front());
    refresh();
    @(negedge clk6x);
    s_tx   = tx;
    s_busy = busy;
    s_done = done;
    s_deq  = ifc.fifo_deq;
    cyc_no++;
  endtask

  task automatic wait_deq(input string nm, output int at);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.fifo_deq === 1'b1) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    at = cyc_no;
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic check_frame(input logic [11:0] fr, input int nbits, input int div, input int len,
                             input int ev_at, input int ev_div, input int ev_cts, input string nm);
    int k, bad_tx, bad_busy, done_cnt, done_at;
    k = 0; bad_tx = 0; bad_busy = 0; done_cnt = 0; done_at = -1;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= div; c++) begin
        cyc();
        k++;
        if (k == ev_at) begin
          if (ev_div >= 0) baud_div = ev_div[15:0];
          if (ev_cts >= 0) cts_n = ev_cts[0];
        end
        if (s_tx !== fr[b]) bad_tx++;
        if (s_busy !== 1'b1) bad_busy++;
        if (s_done === 1'b1) begin
          done_cnt++;
          if (done_at < 0) done_at = k;
        end
      end
    end
    chk({nm, " tx bits"}, bad_tx, 0);
    chk({nm, " busy"}, bad_busy, 0);
    chk({nm, " done count"}, done_cnt, 1);
    chk({nm, " done cycle"}, done_at, len);
  endtask

  task automatic idle_check(input string nm, input logic exp_deq);
    cyc();
    chk(nm, {28'd0, s_tx, s_busy, s_done, s_deq}, {28'd0, 1'b1, 1'b0, 1'b0, exp_deq});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0, d1, lat;
    logic got;

    vt[0] = '{8'h55, 16'd4, 2'b00, 1'b0, 12'h2AA, 10, 50};
    vt[1] = '{8'h07, 16'd2, 2'b10, 1'b0, 12'h60E, 11, 33};
    vt[2] = '{8'h07, 16'd2, 2'b01, 1'b0, 12'h40E, 11, 33};
    vt[3] = '{8'h80, 16'd1, 2'b11, 1'b0, 12'h300, 10, 20};
    vt[4] = '{8'h00, 16'd1, 2'b01, 1'b1, 12'hE00, 12, 24};
    vt[5] = '{8'hC4, 16'd0, 2'b10, 1'b0, 12'h788, 11, 11};

    resetn = 1'b0; cts_n = 1'b0; baud_div = 16'd4; parity = 2'b00; two_stop = 1'b0;
    refresh();
    cyc();
    cyc();
    chk("reset outputs", {28'd0, s_tx, s_busy, s_done, s_deq}, 32'b1000);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    for (int i = 0; i < 6; i++) begin
      baud_div = vt[i].div; parity = vt[i].par; two_stop = vt[i].two;
      push(vt[i].data);
      wait_deq($sformatf("vec%0d deq", i), d0);
      check_frame(vt[i].frame, vt[i].nbits, int'(vt[i].div), vt[i].len, 0, -1, -1, $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d idle", i), 1'b0);
    end
    chk("fifo empty after table", q.size(), 0);

    // back-to-back, two stop bits, divisor 0
    baud_div = 16'd0; parity = 2'b00; two_stop = 1'b1;
    push(8'hA3);
    push(8'hFF);
    wait_deq("b2b first deq", d0);
    check_frame(12'h746, 11, 0, 11, 0, -1, -1, "b2b A3");
    idle_check("b2b gap", 1'b1);
    d1 = cyc_no;
    chk("b2b deq spacing", d1 - d0, 12);
    check_frame(12'h7FE, 11, 0, 11, 0, -1, -1, "b2b FF");
    idle_check("b2b end", 1'b0);

    // divisor change mid-frame only affects the following frame
    baud_div = 16'd4; two_stop = 1'b0;
    push(8'h55);
    wait_deq("cfg deq1", d0);
    check_frame(12'h2AA, 10, 4, 50, 7, 9, -1, "cfg frame1");
    idle_check("cfg idle1", 1'b0);
    push(8'h55);
    wait_deq("cfg deq2", d0);
    check_frame(12'h2AA, 10, 9, 100, 0, -1, -1, "cfg frame2");
    idle_check("cfg idle2", 1'b0);

    // reset during DATA bit 3
    baud_div = 16'd4;
    push(8'h55);
    wait_deq("rst deq", d0);
    for (int i = 0; i < 22; i++) cyc();
    chk("rst pre tx", {31'd0, s_tx}, 32'd0);
    resetn = 1'b0;
    push(8'h3C);
    cyc();
    chk("rst first cycle", {28'd0, s_tx, s_busy, s_done, s_deq}, 32'b1000);
    cyc();
    chk("rst no deq", {31'd0, s_deq}, 32'd0);
    chk("rst fifo untouched", q.size(), 1);
    resetn = 1'b1;
    wait_deq("rst recover deq", d0);
    check_frame(12'h278, 10, 4, 50, 0, -1, -1, "rst recover");
    idle_check("rst recover idle", 1'b0);

    // CTS gating, then CTS deasserted mid-frame
    baud_div = 16'd2;
    cts_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    push(8'h5A);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (s_deq !== 1'b0 || s_tx !== 1'b1) lat++;
    end
    chk("cts blocked", lat, 0);
    cts_n = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      lat++;
      if (s_deq === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("cts deq latency", {31'd0, got && lat >= 2 && lat <= 3}, 32'd1);
    check_frame(12'h2B4, 10, 2, 30, 10, -1, 1, "cts frame");
    idle_check("cts idle", 1'b0);
    cts_n = 1'b0;

    chk("deq while empty", deq_empty_err, 0);
    chk("deq consecutive", deq_dbl_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
